servo_slew_ctrl: RTL and testbench
==================================

Name: servo_slew_ctrl

Overview:
Sequencer in front of servo_pos_drive. Accepts target pulse widths over a valid/ready handshake, clamps them to a safe range, and ramps the commanded pulse_time toward the target by at most `step` clock counts per servo frame. This keeps servo moves smooth and bounded. pulse_time feeds servo_pos_drive.pulseTime directly and only changes on frame boundaries.

Parameters:
FRAME_CYCLES, 2000000, clocks per update frame; tick period.
MIN_PULSE, 50000, lowest legal pulse_time (clocks).
MAX_PULSE, 100000, highest legal pulse_time (clocks).
INIT_PULSE, 75000, pulse_time and target after reset; must satisfy MIN_PULSE <= INIT_PULSE <= MAX_PULSE.
HOLD_FRAMES, 50, idle frames before PWM release (optional feature only).

Ports:
clock_clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = frame counter runs; 0 = counter held at 0, no ticks, pulse_time frozen
tgt_valid  in  1  target offered
tgt_ready  out  1  target can be accepted
tgt_pulse  in  32  requested pulse width (clocks)
step  in  32  max change per frame; 0 = jump directly to target
pulse_time  out  32  command to servo_pos_drive.pulseTime
frame_tick  out  1  one-cycle strobe at frame end
busy  out  1  ramp in progress
at_target  out  1  pulse_time == latched target
clamped  out  1  last accepted target was clamped

Behaviour:
- Reset (sync, active-high; applies mid-ramp too): pulse_time=INIT_PULSE, target_r=INIT_PULSE, frame counter=0, frame_tick=0, busy=0, at_target=1, clamped=0, tgt_ready=0. tgt_ready is a register and goes to 1 on the first clock after reset deasserts. It then stays 1.
- Accept: happens when tgt_valid && tgt_ready at a clock edge. target_r <= clamp(tgt_pulse, MIN_PULSE, MAX_PULSE). clamped <= 1 if tgt_pulse was outside the range, else 0. clamped holds its value until the next accept. A new accept overrides the old target mid-ramp.
- Frame counter: counts 0..FRAME_CYCLES-1 while enable=1. frame_tick=1 (registered) in the cycle the counter wraps from FRAME_CYCLES-1 to 0.
- FSM states:
  - IDLE: pulse_time == target_r.
  - RAMP: pulse_time != target_r.
  - IDLE->RAMP on the cycle after an accept with a differing clamped target.
  - RAMP->IDLE on the tick where pulse_time reaches target_r.
  - RAMP->IDLE on the cycle after an accept equal to the current pulse_time.
  - busy = (state == RAMP). at_target = !busy, registered.
- Ramp update, only on frame_tick cycles while in RAMP:
  - Compute diff = |target_r - pulse_time| in 33-bit unsigned arithmetic; no wrap is allowed.
  - If step == 0 or diff <= step: pulse_time <= target_r.
  - Otherwise: pulse_time <= pulse_time ± step, toward the target.
  - pulse_time never leaves [MIN_PULSE, MAX_PULSE].
- Simultaneous accept and frame_tick: the ramp update uses the pre-edge target_r. The new target takes effect from the next tick.
- step changes take effect at the next tick; step is sampled on the tick cycle.
- enable=0 mid-ramp: the ramp pauses, state is kept, and accepts are still taken. When enable returns to 1, the counter restarts from 0.
- Latency:
  - Accept to busy=1: 1 cycle.
  - Accept to first pulse_time change: the next frame_tick after the accept edge.

Optional Feature:
SERVO_SLEW_HOLD_RELEASE_EN:
- Defined: adds output port pwm_en (1 bit, reset value 1). An idle counter increments on each frame_tick while in IDLE. After HOLD_FRAMES consecutive idle ticks, pwm_en <= 0; the integrator wires pwm_en to servo_pos_drive.reset_low so the servo is released. Any accept clears the idle counter and sets pwm_en <= 1 on the next edge. Entering RAMP also clears the idle counter.
- Undefined: there is no idle counter and no pwm_en port; the driver reset is wired independently.

Decomposition:
- Package servo_ctrl_pkg holds:
  - the state enum (IDLE, RAMP);
  - 32-bit pulse width type;
  - default timing constants (FRAME_CYCLES, MIN/MAX/INIT pulse for 50 MHz).
- Sub-module servo_frame_timer: frame counter plus frame_tick generation, with enable gating. It is reusable by other PWM controllers. The remainder (handshake, clamp, FSM, ramp arithmetic) stays in servo_slew_ctrl.

Test Plan:
Bench parameters for all scenarios: FRAME_CYCLES=10, MIN=100, MAX=200, INIT=150.
1. Reset then idle: after reset release, pulse_time=150, at_target=1, busy=0, tgt_ready=1 from cycle 1; frame_tick every 10 cycles.
2. Ramp up: accept tgt_pulse=175, step=10 -> pulse_time 160, 170, 175 on three consecutive ticks; busy drops the cycle after the 175 tick.
3. Clamp: accept 500 -> target_r=200, clamped=1; accept 0 -> target_r=100, clamped=1; accept 120 -> clamped=0.
4. Retarget mid-ramp plus simultaneous edge: ramping 150->200 with step=10; on a tick cycle, accept 130 -> that tick yields 160; subsequent ticks yield 150, 140, 130.
5. step=0 jump and enable gating: step=0, accept 110 -> pulse_time=110 on the next tick. Then enable=0 for 30 cycles -> no ticks, pulse_time unchanged. Reset asserted mid-ramp -> pulse_time=150 next edge.
6. With SERVO_SLEW_HOLD_RELEASE_EN, HOLD_FRAMES=3: 3 idle ticks -> pwm_en=0; accept 140 -> pwm_en=1 next edge.

Source files
------------

// File: rtl/servo_ctrl_pkg.sv
// Shared types and default 50 MHz timing constants for the servo slew controller.
package servo_ctrl_pkg;

    localparam int unsigned PW = 32;

    typedef logic [PW-1:0] pulse_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam int unsigned DEF_FRAME_CYCLES = 2000000;
    localparam int unsigned DEF_MIN_PULSE    = 50000;
    localparam int unsigned DEF_MAX_PULSE    = 100000;
    localparam int unsigned DEF_INIT_PULSE   = 75000;
    localparam int unsigned DEF_HOLD_FRAMES  = 50;

    function automatic pulse_t clamp_pulse(input pulse_t v, input pulse_t lo, input pulse_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/servo_slew_ctrl_frame_timer.sv
// servo_frame_timer: free-running frame counter with a registered end-of-frame strobe.
// Disabling holds the counter at zero so a re-enable always starts a full frame.
module servo_frame_timer #(
    parameter int unsigned FRAME_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic frame_tick
);

    localparam int unsigned CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else if (cnt == CW'(FRAME_CYCLES - 1)) begin
            cnt        <= '0;
            frame_tick <= 1'b1;
        end else begin
            cnt        <= cnt + CW'(1);
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/servo_slew_ctrl.sv
// Target handshake, clamp and per-frame slew limiter feeding servo_pos_drive.pulseTime.
// Optional SERVO_SLEW_HOLD_RELEASE_EN adds pwm_en, dropped after HOLD_FRAMES idle frames.
module servo_slew_ctrl
    import servo_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int unsigned MIN_PULSE    = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE    = DEF_MAX_PULSE,
    parameter int unsigned INIT_PULSE   = DEF_INIT_PULSE
`ifdef SERVO_SLEW_HOLD_RELEASE_EN
    , parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES
`endif
) (
    input  logic          clock_clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    input  logic [PW-1:0] tgt_pulse,
    input  logic [PW-1:0] step,
    output logic [PW-1:0] pulse_time,
    output logic          frame_tick,
    output logic          busy,
    output logic          at_target,
    output logic          clamped
`ifdef SERVO_SLEW_HOLD_RELEASE_EN
    , output logic        pwm_en
`endif
);

    state_t  state, state_next;
    pulse_t  target_r, target_next, pulse_next, tgt_clamped;
    logic    accept, out_of_range;
    logic [PW:0] diff;

    servo_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_timer (
        .clk       (clock_clk),
        .reset     (reset),
        .enable    (enable),
        .frame_tick(frame_tick)
    );

    assign accept = tgt_valid & tgt_ready;

    // Ramp step uses the pre-edge target; the FSM settles on where pulse and target land.
    always_comb begin
        tgt_clamped  = clamp_pulse(tgt_pulse, PW'(MIN_PULSE), PW'(MAX_PULSE));
        out_of_range = (tgt_pulse < PW'(MIN_PULSE)) || (tgt_pulse > PW'(MAX_PULSE));
        diff         = (target_r >= pulse_time) ? ({1'b0, target_r} - {1'b0, pulse_time})
                                                : ({1'b0, pulse_time} - {1'b0, target_r});
        pulse_next   = pulse_time;
        target_next  = target_r;
        state_next   = state;
        if (frame_tick && state == RAMP) begin
            if (step == '0 || diff <= {1'b0, step}) pulse_next = target_r;
            else if (target_r > pulse_time)         pulse_next = pulse_time + step;
            else                                    pulse_next = pulse_time - step;
        end
        if (accept) target_next = tgt_clamped;
        state_next = (pulse_next == target_next) ? IDLE : RAMP;
    end

    always_ff @(posedge clock_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock_clk) begin
        if (reset) begin
            pulse_time <= PW'(INIT_PULSE);
            target_r   <= PW'(INIT_PULSE);
            clamped    <= 1'b0;
            tgt_ready  <= 1'b0;
            busy       <= 1'b0;
            at_target  <= 1'b1;
        end else begin
            pulse_time <= pulse_next;
            target_r   <= target_next;
            tgt_ready  <= 1'b1;
            busy       <= (state_next == RAMP);
            at_target  <= (state_next == IDLE);
            if (accept) clamped <= out_of_range;
        end
    end

`ifdef SERVO_SLEW_HOLD_RELEASE_EN
    logic [31:0] idle_cnt;

    // Count consecutive idle frames; saturate once the servo has been released.
    always_ff @(posedge clock_clk) begin
        if (reset) begin
            idle_cnt <= '0;
            pwm_en   <= 1'b1;
        end else if (accept) begin
            idle_cnt <= '0;
            pwm_en   <= 1'b1;
        end else if (state == RAMP || state_next == RAMP) begin
            idle_cnt <= '0;
        end else if (frame_tick && pwm_en) begin
            if (idle_cnt + 32'd1 >= HOLD_FRAMES) pwm_en <= 1'b0;
            else                                 idle_cnt <= idle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed bench for servo_slew_ctrl with a queue of expected pulse_time values per tick.
// Define SERVO_SLEW_HOLD_RELEASE_EN to also exercise the pwm_en release path.
module tb_servo_slew_ctrl;

    logic        clock_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [31:0] tgt_pulse;
    logic [31:0] step;
    logic [31:0] pulse_time;
    logic        frame_tick;
    logic        busy;
    logic        at_target;
    logic        clamped;
`ifdef SERVO_SLEW_HOLD_RELEASE_EN
    logic        pwm_en;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clock_clk = ~clock_clk;

    servo_slew_ctrl #(
        .FRAME_CYCLES(10),
        .MIN_PULSE   (100),
        .MAX_PULSE   (200),
        .INIT_PULSE  (150)
`ifdef SERVO_SLEW_HOLD_RELEASE_EN
        , .HOLD_FRAMES(3)
`endif
    ) dut (
        .clock_clk (clock_clk),
        .reset     (reset),
        .enable    (enable),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_pulse (tgt_pulse),
        .step      (step),
        .pulse_time(pulse_time),
        .frame_tick(frame_tick),
        .busy      (busy),
        .at_target (at_target),
        .clamped   (clamped)
`ifdef SERVO_SLEW_HOLD_RELEASE_EN
        , .pwm_en  (pwm_en)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge inside the next tick cycle; n = negedges waited.
    task automatic wait_tick(output int n);
        logic got;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock_clk);
            n++;
            if (frame_tick === 1'b1) got = 1'b1;
        end
        chk("tick_seen", 32'(got), 32'd1);
    endtask

    task automatic tick_check(input string tag);
        int n;
        logic [31:0] e;
        wait_tick(n);
        @(negedge clock_clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%0d expected=<none queued>", tag, pulse_time);
        end else begin
            e = exp_q.pop_front();
            chk(tag, pulse_time, e);
        end
    endtask

    task automatic send(input logic [31:0] v);
        tgt_valid = 1'b1;
        tgt_pulse = v;
        @(negedge clock_clk);
        tgt_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ticks;
        reset = 1'b1; enable = 1'b1; tgt_valid = 1'b0; tgt_pulse = '0; step = 32'd10;
        repeat (3) @(negedge clock_clk);

        // Reset state and idle tick cadence
        chk("rst_ready", 32'(tgt_ready), 32'd0);
        chk("rst_pulse", pulse_time, 32'd150);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_at_target", 32'(at_target), 32'd1);
        chk("rst_clamped", 32'(clamped), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
`ifdef SERVO_SLEW_HOLD_RELEASE_EN
        chk("rst_pwm_en", 32'(pwm_en), 32'd1);
`endif
        reset = 1'b0;
        @(negedge clock_clk);
        chk("ready_cycle1", 32'(tgt_ready), 32'd1);
        wait_tick(n);
        chk("first_tick_gap", 32'(n), 32'd9);
        wait_tick(n);
        chk("tick_period", 32'(n), 32'd10);
        @(negedge clock_clk);
        chk("idle_pulse", pulse_time, 32'd150);

        // Ramp up 150 -> 175 with step 10
        step = 32'd10;
        send(32'd175);
        chk("ramp_busy", 32'(busy), 32'd1);
        chk("ramp_not_at", 32'(at_target), 32'd0);
        chk("ramp_clamped", 32'(clamped), 32'd0);
        exp_q.push_back(32'd160); exp_q.push_back(32'd170); exp_q.push_back(32'd175);
        tick_check("ramp_160");
        chk("ramp_busy_mid", 32'(busy), 32'd1);
        tick_check("ramp_170");
        tick_check("ramp_175");
        chk("ramp_done_busy", 32'(busy), 32'd0);
        chk("ramp_done_at", 32'(at_target), 32'd1);

        // Clamping, observed through step=0 jumps
        step = 32'd0;
        send(32'd500);
        chk("clamp_hi_flag", 32'(clamped), 32'd1);
        exp_q.push_back(32'd200);
        tick_check("clamp_hi_pulse");
        send(32'd0);
        chk("clamp_lo_flag", 32'(clamped), 32'd1);
        exp_q.push_back(32'd100);
        tick_check("clamp_lo_pulse");
        send(32'd120);
        chk("clamp_none_flag", 32'(clamped), 32'd0);
        exp_q.push_back(32'd120);
        tick_check("clamp_none_pulse");

        // Retarget on the same edge as a tick
        send(32'd150);
        exp_q.push_back(32'd150);
        tick_check("pre_retarget");
        step = 32'd10;
        send(32'd200);
        wait_tick(n);
        tgt_valid = 1'b1;
        tgt_pulse = 32'd130;
        @(negedge clock_clk);
        tgt_valid = 1'b0;
        chk("retarget_tick", pulse_time, 32'd160);
        exp_q.push_back(32'd150); exp_q.push_back(32'd140); exp_q.push_back(32'd130);
        tick_check("retarget_150");
        tick_check("retarget_140");
        chk("retarget_busy", 32'(busy), 32'd1);
        tick_check("retarget_130");
        chk("retarget_at", 32'(at_target), 32'd1);

        // step=0 jump, then enable gating with an accept during the pause
        step = 32'd0;
        send(32'd110);
        exp_q.push_back(32'd110);
        tick_check("jump_110");
        enable = 1'b0;
        step = 32'd10;
        tgt_valid = 1'b1;
        tgt_pulse = 32'd180;
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock_clk);
            tgt_valid = 1'b0;
            if (frame_tick === 1'b1) ticks++;
        end
        chk("paused_ticks", 32'(ticks), 32'd0);
        chk("paused_pulse", pulse_time, 32'd110);
        chk("paused_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        wait_tick(n);
        chk("reenable_gap", 32'(n), 32'd10);
        @(negedge clock_clk);
        exp_q.push_back(32'd120);
        chk("resume_120", pulse_time, exp_q.pop_front());

        // Reset in the middle of a ramp
        reset = 1'b1;
        @(negedge clock_clk);
        chk("midreset_pulse", pulse_time, 32'd150);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_at", 32'(at_target), 32'd1);
        chk("midreset_ready", 32'(tgt_ready), 32'd0);
        reset = 1'b0;
        @(negedge clock_clk);
        chk("postreset_ready", 32'(tgt_ready), 32'd1);

`ifdef SERVO_SLEW_HOLD_RELEASE_EN
        // Hold release after three idle frames
        wait_tick(n);
        @(negedge clock_clk);
        wait_tick(n);
        @(negedge clock_clk);
        chk("hold_2_ticks", 32'(pwm_en), 32'd1);
        wait_tick(n);
        @(negedge clock_clk);
        chk("hold_released", 32'(pwm_en), 32'd0);
        send(32'd140);
        chk("hold_reacquire", 32'(pwm_en), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
